// File: rtl/paged_memory_controller.sv
// paged_memory_controller: memory controller that translates virtual addresses through a TLB with page-table walk and req/ack RAM access.
// Defining MMU_ALIGN_CHECK_EN faults word-misaligned requests at accept.
module paged_memory_controller #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int PAGE_BITS = 12,
  parameter int TLB_ENTRIES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] mc_addr,
  input  logic [DATA_W-1:0] mc_wdata,
  input  logic              mc_read_req,
  input  logic              mc_write_req,
  input  logic              mc_addr_virtual,
  input  logic              mc_exec_mode,
  input  logic [ADDR_W-1:0] pt_base,
  input  logic              tlb_flush,
  output logic [DATA_W-1:0] mc_rdata,
  output logic [1:0]        mc_status,
  output logic [ADDR_W-1:0] ph_addr,
  output logic [DATA_W-1:0] ph_wdata,
  output logic              ph_read_req,
  output logic              ph_write_req,
  input  logic [DATA_W-1:0] ph_rdata,
  input  logic              ph_ack
);
  localparam int VPN_W = ADDR_W - PAGE_BITS;
  localparam int FRM_W = 32 - PAGE_BITS;
  localparam int PTR_W = $clog2(TLB_ENTRIES);
  typedef enum logic [2:0] {IDLE, WALK, ACCESS, DONE, FAULT} state_t;
  state_t                 state_q;
  logic [TLB_ENTRIES-1:0] tlb_valid_q, tlb_wr_q;
  logic [VPN_W-1:0]       tlb_vpn_q [TLB_ENTRIES];
  logic [FRM_W-1:0]       tlb_frm_q [TLB_ENTRIES];
  logic [PTR_W-1:0]       ptr_q;
  logic [ADDR_W-1:0]      addr_q;
  logic                   wr_q, exec_q;
  logic                   hit, hit_wr, misalign;
  logic [FRM_W-1:0]       hit_frm;
  logic [VPN_W-1:0]       vpn;
  assign vpn = mc_addr[ADDR_W-1:PAGE_BITS];
`ifdef MMU_ALIGN_CHECK_EN
  assign misalign = |mc_addr[$clog2(DATA_W/8)-1:0];
`else
  assign misalign = 1'b0;
`endif
  function automatic logic [ADDR_W-1:0] phys(input logic [FRM_W-1:0] f, input logic [PAGE_BITS-1:0] o);
    return ADDR_W'({f, o});
  endfunction
  always_comb begin
    hit = 1'b0;
    hit_wr = 1'b0;
    hit_frm = '0;
    for (int i = 0; i < TLB_ENTRIES; i++)
      if (tlb_valid_q[i] && tlb_vpn_q[i] == vpn) begin
        hit = 1'b1;
        hit_wr = tlb_wr_q[i];
        hit_frm = tlb_frm_q[i];
      end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tlb_valid_q <= '0;
      ptr_q <= '0;
      mc_status <= 2'd0;
      mc_rdata <= '0;
      ph_read_req <= 1'b0;
      ph_write_req <= 1'b0;
      ph_addr <= '0;
      ph_wdata <= '0;
    end else begin
      case (state_q)
        IDLE: if (mc_read_req || mc_write_req) begin
          addr_q <= mc_addr;
          wr_q <= mc_write_req;
          exec_q <= mc_exec_mode;
          ph_wdata <= mc_wdata;
          if (misalign || (mc_addr_virtual && hit && mc_write_req && !hit_wr && !mc_exec_mode)) begin
            state_q <= FAULT;
            mc_status <= 2'd3;
          end else if (mc_addr_virtual && !hit) begin
            state_q <= WALK;
            mc_status <= 2'd1;
            ph_read_req <= 1'b1;
            ph_addr <= pt_base + ADDR_W'({vpn, 2'b00});
          end else begin
            state_q <= ACCESS;
            mc_status <= 2'd1;
            ph_addr <= mc_addr_virtual ? phys(hit_frm, mc_addr[PAGE_BITS-1:0]) : mc_addr;
            ph_read_req <= !mc_write_req;
            ph_write_req <= mc_write_req;
          end
        end
        WALK: if (ph_ack) begin
          ph_read_req <= 1'b0;
          if (!ph_rdata[0]) begin
            state_q <= FAULT;
            mc_status <= 2'd3;
          end else begin
            tlb_valid_q[ptr_q] <= 1'b1;
            tlb_wr_q[ptr_q] <= ph_rdata[1];
            tlb_vpn_q[ptr_q] <= addr_q[ADDR_W-1:PAGE_BITS];
            tlb_frm_q[ptr_q] <= ph_rdata[PAGE_BITS +: FRM_W];
            ptr_q <= ptr_q + 1'b1;
            if (wr_q && !ph_rdata[1] && !exec_q) begin
              state_q <= FAULT;
              mc_status <= 2'd3;
            end else begin
              state_q <= ACCESS;
              ph_addr <= phys(ph_rdata[PAGE_BITS +: FRM_W], addr_q[PAGE_BITS-1:0]);
              ph_read_req <= !wr_q;
              ph_write_req <= wr_q;
            end
          end
        end
        ACCESS: if (ph_ack) begin
          ph_read_req <= 1'b0;
          ph_write_req <= 1'b0;
          if (!wr_q) mc_rdata <= ph_rdata;
          state_q <= DONE;
          mc_status <= 2'd2;
        end
        default: if (!mc_read_req && !mc_write_req) begin
          state_q <= IDLE;
          mc_status <= 2'd0;
        end
      endcase
      // a flush overrides any fill landing on the same edge
      if (tlb_flush) tlb_valid_q <= '0;
    end
  end
endmodule

// File: tb/tb_paged_memory_controller.sv
// tb_paged_memory_controller: directed and randomized checks of the paged memory controller against a page-level reference model.
module tb_paged_memory_controller;
  localparam int TLB_N = 4;
`ifdef MMU_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  typedef struct packed {logic we; logic [31:0] a; logic [31:0] d;} acc_t;
  logic clk = 0, reset = 1;
  logic [31:0] mc_addr = 0, mc_wdata = 0, pt_base = 32'h1000, mc_rdata, ph_addr, ph_wdata, ph_rdata = 0;
  logic mc_read_req = 0, mc_write_req = 0, mc_addr_virtual = 0, mc_exec_mode = 0, tlb_flush = 0;
  logic ph_read_req, ph_write_req, ph_ack = 0;
  logic [1:0] mc_status;
  int checks = 0, errors = 0, lat = 0, cnt = 0;
  logic [31:0] mem [logic [31:0]];
  acc_t log_q[$], exp_q[$];
  bit m_valid [TLB_N];
  bit m_wr [TLB_N];
  logic [19:0] m_vpn [TLB_N];
  logic [19:0] m_frame [TLB_N];
  int m_ptr = 0;
  logic [31:0] m_rdata = 0;
  logic prev_r = 0, prev_w = 0;
  logic [31:0] prev_a = 0, prev_d = 0;

  paged_memory_controller dut (
    .clk(clk), .reset(reset), .mc_addr(mc_addr), .mc_wdata(mc_wdata),
    .mc_read_req(mc_read_req), .mc_write_req(mc_write_req), .mc_addr_virtual(mc_addr_virtual),
    .mc_exec_mode(mc_exec_mode), .pt_base(pt_base), .tlb_flush(tlb_flush), .mc_rdata(mc_rdata),
    .mc_status(mc_status), .ph_addr(ph_addr), .ph_wdata(ph_wdata), .ph_read_req(ph_read_req),
    .ph_write_req(ph_write_req), .ph_rdata(ph_rdata), .ph_ack(ph_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // RAM: ack tied high when lat is 0, otherwise a one-cycle ack after lat waiting cycles
  always @(negedge clk) begin
    if (lat == 0) ph_ack = 1'b1;
    else if (ph_ack) begin
      ph_ack = 1'b0;
      cnt = 0;
    end else if (ph_read_req || ph_write_req) begin
      if (cnt >= lat) ph_ack = 1'b1;
      else cnt++;
    end else cnt = 0;
    ph_rdata = mem_rd(ph_addr);
  end

  always @(posedge clk) begin
    #1;
    if (!reset) begin
      if ((prev_r || prev_w) && ph_ack) begin
        log_q.push_back({prev_w, prev_a, prev_d});
        if (prev_w) mem[prev_a] = prev_d;
      end else if (prev_r || prev_w) begin
        chk("hold_req", {ph_read_req, ph_write_req}, {prev_r, prev_w});
        chk("hold_addr", ph_addr, prev_a);
      end
      chk("req_onehot", ph_read_req & ph_write_req, 0);
    end
    prev_r = ph_read_req;
    prev_w = ph_write_req;
    prev_a = ph_addr;
    prev_d = ph_wdata;
  end

  task automatic model_clear();
    for (int i = 0; i < TLB_N; i++) m_valid[i] = 0;
  endtask

  task automatic predict(input bit virt, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                         input bit ex, output bit fault, output int ed);
    int idx;
    logic [31:0] pte, pa;
    logic [19:0] vpn, frame;
    bit w;
    exp_q.delete();
    fault = 0;
    ed = 1;
    pa = addr;
    if (ALIGN && addr[1:0] != 0) begin
      fault = 1;
      ed = 0;
      return;
    end
    if (virt) begin
      vpn = addr[31:12];
      idx = -1;
      frame = 0;
      w = 0;
      for (int i = 0; i < TLB_N; i++)
        if (m_valid[i] && m_vpn[i] == vpn) idx = i;
      if (idx >= 0) begin
        frame = m_frame[idx];
        w = m_wr[idx];
      end else begin
        pte = mem_rd(pt_base + {vpn, 2'b00});
        exp_q.push_back({1'b0, pt_base + {10'h0, vpn, 2'b00}, 32'h0});
        ed = 2;
        if (!pte[0]) begin
          fault = 1;
          ed = 1;
          return;
        end
        frame = pte[31:12];
        w = pte[1];
        m_valid[m_ptr] = 1;
        m_vpn[m_ptr] = vpn;
        m_frame[m_ptr] = frame;
        m_wr[m_ptr] = w;
        m_ptr = (m_ptr + 1) % TLB_N;
      end
      if (wr && !w && !ex) begin
        fault = 1;
        ed = (idx >= 0) ? 0 : 1;
        return;
      end
      pa = {frame, addr[11:0]};
    end
    exp_q.push_back({wr, pa, wd});
    if (!wr) m_rdata = mem_rd(pa);
  endtask

  task automatic op(input bit virt, input bit wr, input bit both, input logic [31:0] addr,
                    input logic [31:0] wd, input bit ex, output int edges);
    bit fault;
    int ed;
    predict(virt, wr, addr, wd, ex, fault, ed);
    @(negedge clk);
    log_q.delete();
    mc_addr = addr;
    mc_wdata = wd;
    mc_addr_virtual = virt;
    mc_exec_mode = ex;
    mc_write_req = wr;
    mc_read_req = !wr || both;
    @(posedge clk); #2;
    if (ed > 0) chk("busy", mc_status, 1);
    edges = 0;
    while (!mc_status[1] && edges < 60) begin
      @(posedge clk); #2;
      edges++;
    end
    chk("status", mc_status, fault ? 2'd3 : 2'd2);
    if (lat == 0) chk("latency", edges, ed);
    chk("acc_count", log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      chk("acc_kind", log_q[i].we, exp_q[i].we);
      chk("acc_addr", log_q[i].a, exp_q[i].a);
      if (exp_q[i].we) chk("acc_wdata", log_q[i].d, exp_q[i].d);
    end
    chk("rdata", mc_rdata, m_rdata);
    @(negedge clk);
    mc_read_req = 0;
    mc_write_req = 0;
    @(posedge clk); #2;
    chk("idle", mc_status, 0);
  endtask

  task automatic set_lat(input int n);
    lat = n;
    repeat (2) @(negedge clk);
  endtask

  task automatic flush_pulse();
    @(negedge clk);
    tlb_flush = 1;
    @(negedge clk);
    tlb_flush = 0;
    model_clear();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int e;
    bit v, w, b, ex;
    logic [31:0] a;
    model_clear();
    mem[32'h1004] = 32'h0000_5003;
    mem[32'h5010] = 32'hCAFE_0001;
    mem[32'h1008] = 32'h0000_6001;
    mem[32'h100C] = 32'h0000_7003;
    mem[32'h1010] = 32'h0000_8003;
    mem[32'h1014] = 32'h0000_9003;
    mem[32'h1018] = 32'h0000_A003;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_status", mc_status, 0);
    chk("rst_rdata", mc_rdata, 0);
    chk("rst_rreq", ph_read_req, 0);
    chk("rst_wreq", ph_write_req, 0);
    chk("rst_addr", ph_addr, 0);
    chk("rst_wdata", ph_wdata, 0);
    @(negedge clk);
    reset = 0;
    op(0, 1, 0, 32'h0, 32'h123, 0, e);
    chk("phys_lat", e, 1);
    op(1, 0, 0, 32'h1010, 0, 0, e);
    chk("miss_lat", e, 2);
    chk("miss_rdata", mc_rdata, 32'hCAFE_0001);
    op(1, 0, 0, 32'h1010, 0, 0, e);
    chk("hit_lat", e, 1);
    op(1, 1, 0, 32'h2004, 32'hAA, 0, e);
    op(1, 1, 0, 32'h2004, 32'hBB, 0, e);
    chk("prot_status", mc_status, 0);
    op(1, 1, 1, 32'h2004, 32'hCC, 1, e);
    chk("super_wr", mem_rd(32'h6004), 32'hCC);
    flush_pulse();
    foreach (a[i]) ;
    op(1, 0, 0, 32'h1010, 0, 0, e);
    op(1, 0, 0, 32'h3000, 0, 0, e);
    op(1, 0, 0, 32'h4000, 0, 0, e);
    op(1, 0, 0, 32'h5000, 0, 0, e);
    op(1, 0, 0, 32'h6000, 0, 0, e);
    op(1, 0, 0, 32'h1010, 0, 0, e);
    chk("rr_evict_lat", e, 2);
    flush_pulse();
    op(1, 0, 0, 32'h3000, 0, 0, e);
    chk("flush_lat", e, 2);
    set_lat(3);
    op(1, 0, 0, 32'h3000, 0, 0, e);
    chk("slow_lat", e, 4);
    flush_pulse();
    @(negedge clk);
    mc_addr = 32'h4000;
    mc_addr_virtual = 1;
    mc_read_req = 1;
    @(posedge clk); #2;
    chk("walk_rreq", ph_read_req, 1);
    chk("walk_addr", ph_addr, 32'h1010);
    @(negedge clk);
    reset = 1;
    mc_read_req = 0;
    @(posedge clk); #2;
    chk("abort_rreq", ph_read_req, 0);
    chk("abort_status", mc_status, 0);
    model_clear();
    m_ptr = 0;
    m_rdata = 0;
    @(negedge clk);
    reset = 0;
    set_lat(0);
    op(1, 0, 0, 32'h7000, 0, 0, e);
    chk("bad_pte_lat", e, 1);
    op(0, 0, 0, 32'h2, 0, 0, e);
    for (int k = 0; k < 8; k++)
      mem[32'h1040 + k * 4] = (k == 7) ? 32'h0 : {12'h0, 8'(8'h20 + k), 10'h0, 1'($urandom_range(0, 1)), 1'b1};
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) == 0) set_lat($urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0) flush_pulse();
      v = $urandom_range(0, 4) != 0;
      w = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      ex = $urandom_range(0, 3) == 0;
      a = v ? {12'h0, 4'h1, 4'($urandom_range(0, 7)), 4'h0, 6'($urandom_range(0, 15)), 2'b00}
            : 32'h30000 + 32'($urandom_range(0, 15)) * 4;
      op(v, w, b, a, $urandom, ex, e);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/paged_memory_controller.md
Name: paged_memory_controller

Overview:
Parametrised successor to the single-word memory controller, sitting between a CPU core and byte-addressed physical RAM.
- Translates virtual addresses through a small fully-associative TLB, backed by a single-level page-table walk in RAM.
- Physical side uses a req/ack handshake, so RAM latency may vary.
- Reports idle/busy/done/fault on a 2-bit status, as the previous generation did.

Parameters:
DATA_W, 32, data word width; multiple of 8, at least 32.
ADDR_W, 32, address width.
PAGE_BITS, 12, page offset bits.
TLB_ENTRIES, 4, TLB entry count; power of 2, at least 2.

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
mc_addr  in  ADDR_W  request address, virtual or physical
mc_wdata  in  DATA_W  write data
mc_read_req  in  1  read request, level
mc_write_req  in  1  write request, level
mc_addr_virtual  in  1  1 = translate mc_addr
mc_exec_mode  in  1  1 = supervisor, bypasses write protection
pt_base  in  ADDR_W  page-table base, physical
tlb_flush  in  1  invalidate all TLB entries
mc_rdata  out  DATA_W  read result
mc_status  out  2  0 idle, 1 busy, 2 done, 3 fault
ph_addr  out  ADDR_W  physical address
ph_wdata  out  DATA_W  physical write data
ph_read_req  out  1  physical read strobe
ph_write_req  out  1  physical write strobe
ph_rdata  in  DATA_W  physical read data
ph_ack  in  1  physical access complete

Behaviour:
- Reset: state IDLE; all TLB valid bits 0; replacement pointer 0; mc_status=0; mc_rdata=0; ph_read_req=0; ph_write_req=0; ph_addr=0; ph_wdata=0. Reset mid-operation aborts immediately and drops ph_*_req in the same cycle.
- PTE format, low 32 bits of the RAM word at pt_base + vpn*4:
  - bit0 valid
  - bit1 writable
  - bits[31:PAGE_BITS] physical frame number
  - vpn = mc_addr[ADDR_W-1:PAGE_BITS]
  - physical address = {frame, mc_addr[PAGE_BITS-1:0]}
- States: IDLE, WALK, ACCESS, DONE, FAULT.
- IDLE:
  - Accepts when mc_read_req or mc_write_req is 1. If both are 1, write wins.
  - Request fields are latched at accept.
  - Physical mode, or virtual with TLB hit: go to ACCESS with ph_*_req registered high.
  - Virtual with TLB miss: go to WALK with ph_read_req=1, ph_addr = pt_base + vpn*4.
  - Hit with a write to a non-writable page while mc_exec_mode=0: go to FAULT, no physical access.
  - mc_status=1 from the cycle after accept.
- WALK: hold request until ph_ack=1. Then:
  - PTE invalid: go to FAULT, TLB unchanged.
  - Valid, but write to non-writable page with exec_mode=0: fill TLB, then go to FAULT.
  - Otherwise: fill the entry at the replacement pointer, increment the pointer (wraps at TLB_ENTRIES), go to ACCESS.
- ACCESS: hold ph_addr, ph_wdata and ph_*_req until ph_ack=1. On ack:
  - deassert the req in the same edge;
  - for reads, mc_rdata <= ph_rdata;
  - go to DONE.
- DONE / FAULT:
  - mc_status is 2 or 3.
  - Stays there until both mc_read_req and mc_write_req are 0, then IDLE and status 0.
  - mc_rdata holds its value until the next read completes.
- Latency with ph_ack tied high (accept edge = 0):
  - physical or TLB hit: status=2 after edge 1;
  - TLB miss: status=2 after edge 2.
- tlb_flush:
  - Clears all valid bits on the edge it is sampled, in any state.
  - A fill in the same cycle loses, so the entry ends up invalid.
  - An in-flight translation already resolved completes normally.
- TLB lookup compares vpn with valid entries combinationally in IDLE. Duplicate entries are impossible because fills happen only on a miss.
- At most one of ph_read_req / ph_write_req is 1 at any time.

Optional Feature:
MMU_ALIGN_CHECK_EN.
- Defined: at accept, mc_addr[log2(DATA_W/8)-1:0] != 0 goes directly to FAULT, with no walk and no physical access.
- Undefined: the address is passed through unaligned and RAM handles it.

Test Plan:
1. Physical write: virtual=0, addr 0x0, wdata 0x123, write_req held, ph_ack tied 1 -> one ph_write_req pulse at ph_addr 0x0 with ph_wdata 0x123; status 1 then 2; returns to 0 the cycle after write_req drops.
2. Virtual read miss then hit:
   - Setup: pt_base 0x1000; RAM[0x1004] = 0x00005003 (frame 5, valid, writable).
   - First read of 0x1010: PTE read at 0x1004, then data read at 0x5010, done after edge 2.
   - Repeat read: single access at 0x5010, done after edge 1.
3. Protection:
   - PTE = 0x00005001 (read-only). Write with exec_mode=0 -> status 3, no ph_write_req.
   - Same write with exec_mode=1 -> write at 0x5xxx, status 2.
4. Replacement and flush:
   - Touch TLB_ENTRIES+1 distinct pages -> the first page misses again (round robin).
   - Pulse tlb_flush -> the next access to any page walks.
5. Variable latency and reset:
   - ph_ack delayed 3 cycles -> ph_read_req and ph_addr held stable throughout; exactly one capture.
   - Separately, assert reset during WALK -> ph_read_req=0 and status=0 the next cycle.
6. Invalid PTE 0x0 -> status 3.
   - With MMU_ALIGN_CHECK_EN: addr 0x2 -> status 3 and no ph request.
   - Without it: addr 0x2 -> access at 0x2.
